// File: rtl/mc_core_ctrl_pkg.sv
// Shared definitions for the multi-cycle core sequencer: FSM state encoding,
// supported RV64 opcodes, ALU operation classes and trap-cause codes.
package mc_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [1:0] {
        AluAddr   = 2'b00,  // ld/sd address add
        AluBranch = 2'b01,  // beq compare
        AluFunct  = 2'b10   // R-type, funct fields decide
    } alu_op_e;

    typedef enum logic [1:0] {
        CauseNone         = 2'd0,
        CauseIllegal      = 2'd1,
        CauseFetchTimeout = 2'd2,
        CauseMemTimeout   = 2'd3
    } trap_cause_e;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OpRtype) || (op == OpLoad) || (op == OpStore) || (op == OpBranch);
    endfunction

    function automatic alu_op_e alu_op_of(input logic [6:0] op);
        alu_op_e res;
        res = AluAddr;
        if (op == OpBranch) begin
            res = AluBranch;
        end else if (op == OpRtype) begin
            res = AluFunct;
        end
        return res;
    endfunction

endpackage

// File: rtl/mc_core_ctrl_if.sv
// Unified memory request/ready bus between the sequencer (master) and memory (slave).
//   mem_req      : request, held until mem_ready is sampled high
//   mem_we       : write strobe, qualified by mem_req
//   mem_addr_sel : address source, 0 = PC, 1 = ALU result
//   mem_ready    : memory accepts/completes the current request
//   mem_rdata    : instruction word, valid with mem_ready during fetch
interface mc_core_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mc_core_ctrl_wait_timer.sv
// Memory watchdog: counts consecutive not-ready cycles of an outstanding access.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear (sequencer state entry)
//   busy       : an access is outstanding this cycle
//   ready      : memory ready this cycle; clears the count
//   expired    : this cycle is the TIMEOUT-th consecutive not-ready cycle
module mc_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Combinational on ready so the trap is taken on the edge that ends the last allowed cycle.
    assign expired = busy && !ready && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || ready) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and instruction register.
//   clk, rst_n  : clock, asynchronous active-low reset
//   mem         : memory request/ready bus (master side)
//   zero, imm   : ALU zero flag and sign-extended branch offset
//   pc, instr   : current instruction address and instruction register
//   reg_we, alu_src, mem_to_reg, alu_op : datapath controls
//   retired, instret : retire pulse and retired-instruction count
//   trap, trap_cause : sticky fault flag and code
module mc_core_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_core_ctrl_if.master    mem,
    input  logic              zero,
    input  logic [XLEN-1:0]   imm,
    output logic [PC_W-1:0]   pc,
    output logic [31:0]       instr,
    output logic              reg_we,
    output logic              alu_src,
    output logic              mem_to_reg,
    output logic [1:0]        alu_op,
    output logic              retired,
    output logic [31:0]       instret,
    output logic              trap,
    output logic [1:0]        trap_cause
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       instret_q, instret_d;
    logic              retired_q, retired_d;
    trap_cause_e       cause_q, cause_d;

    logic [6:0]        opcode;
    logic              wd_busy, wd_clr, wd_expired;
    logic              unused_imm;

    assign opcode     = instr_q[6:0];
    assign unused_imm = ^imm[XLEN-1:PC_W];

    assign wd_busy = (state_q == StFetch) || (state_q == StMem);
    assign wd_clr  = (state_d != state_q);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .busy    (wd_busy),
        .ready   (mem.mem_ready),
        .expired (wd_expired)
    );

    // Next-state logic; mem_ready and zero only ever reach registers from here.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = 1'b0;
        cause_d   = cause_q;

        case (state_q)
            StFetch: begin
                if (mem.mem_ready) begin
                    instr_d = mem.mem_rdata;
                    state_d = StDecode;
                end else if (wd_expired) begin
                    state_d = StTrap;
                    cause_d = CauseFetchTimeout;
                end
            end
            StDecode: begin
                if (is_legal(opcode)) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end
            end
            StExec: begin
                case (opcode)
                    OpRtype:         state_d = StWb;
                    OpLoad, OpStore: state_d = StMem;
                    OpBranch: begin
                        pc_d      = zero ? (pc_q + imm[PC_W-1:0]) : (pc_q + PC_W'(4));
                        retired_d = 1'b1;
                        state_d   = StFetch;
                    end
                    default: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                endcase
            end
            StMem: begin
                if (mem.mem_ready) begin
                    if (opcode == OpStore) begin
                        pc_d      = pc_q + PC_W'(4);
                        retired_d = 1'b1;
                        state_d   = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wd_expired) begin
                    state_d = StTrap;
                    cause_d = CauseMemTimeout;
                end
            end
            StWb: begin
                pc_d      = pc_q + PC_W'(4);
                retired_d = 1'b1;
                state_d   = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        instret_d = instret_q + 32'(retired_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            instr_q   <= '0;
            instret_q <= '0;
            retired_q <= 1'b0;
            cause_q   <= CauseNone;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    // Moore outputs: decoded from state and the instruction register only.
    always_comb begin
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        reg_we           = 1'b0;
        alu_src          = 1'b0;
        mem_to_reg       = 1'b0;
        alu_op           = AluAddr;

        case (state_q)
            StFetch: begin
                mem.mem_req = 1'b1;
            end
            StExec: begin
                alu_op  = alu_op_of(opcode);
                alu_src = (opcode == OpLoad) || (opcode == OpStore);
            end
            StMem: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = (opcode == OpStore);
                alu_op           = alu_op_of(opcode);
                alu_src          = 1'b1;
            end
            StWb: begin
                reg_we     = 1'b1;
                mem_to_reg = (opcode == OpLoad);
                alu_op     = alu_op_of(opcode);
                alu_src    = (opcode == OpLoad) || (opcode == OpStore);
            end
            default: begin
            end
        endcase
    end

    assign pc         = pc_q;
    assign instr      = instr_q;
    assign instret    = instret_q;
    assign retired    = retired_q;
    assign trap       = (state_q == StTrap);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Directed bench for mc_core_ctrl: inputs change and outputs are checked at the
// falling edge, between the rising edges where the DUT updates.
module tb_mc_core_ctrl;

    localparam logic [31:0] InstrR   = 32'h00B50533;
    localparam logic [31:0] InstrBeq = 32'h00000063;
    localparam logic [31:0] InstrLd  = 32'h00000003;
    localparam logic [31:0] InstrSd  = 32'h00000023;
    localparam logic [31:0] InstrIll = 32'h00000013;
    localparam logic [63:0] ImmM8    = 64'hFFFF_FFFF_FFFF_FFF8;

    logic        clk;
    logic        rst_n;
    logic        zero;
    logic [63:0] imm;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        reg_we, alu_src, mem_to_reg;
    logic [1:0]  alu_op;
    logic        retired;
    logic [31:0] instret;
    logic        trap;
    logic [1:0]  trap_cause;

    int n_assert = 0;
    int n_fail   = 0;

    mc_core_ctrl_if mem_bus ();

    mc_core_ctrl #(
        .PC_W    (8),
        .XLEN    (64),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem        (mem_bus),
        .zero       (zero),
        .imm        (imm),
        .pc         (pc),
        .instr      (instr),
        .reg_we     (reg_we),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .retired    (retired),
        .instret    (instret),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // R-type with zero wait-states, starting and ending in FETCH.
    task automatic do_r(input logic [7:0] start_pc, input logic [31:0] exp_ret);
        logic [7:0] npc;
        npc = start_pc + 8'd4;
        chk("r_fetch_pc", 64'(pc), 64'(start_pc));
        mem_bus.mem_rdata = InstrR;
        mem_bus.mem_ready = 1'b1;
        cyc();
        chk("r_dec_req", 64'(mem_bus.mem_req), 0);
        chk("r_dec_retired", 64'(retired), 0);
        cyc();
        cyc();
        chk("r_wb_regwe", 64'(reg_we), 1);
        cyc();
        chk("r_done_pc", 64'(pc), 64'(npc));
        chk("r_done_retired", 64'(retired), 1);
        chk("r_done_instret", 64'(instret), 64'(exp_ret));
    endtask

    task automatic do_beq(input logic [7:0] start_pc, input logic z, input logic [63:0] immv,
                          input logic [7:0] exp_pc, input logic [31:0] exp_ret);
        chk("beq_fetch_pc", 64'(pc), 64'(start_pc));
        mem_bus.mem_rdata = InstrBeq;
        mem_bus.mem_ready = 1'b1;
        zero = z;
        imm  = immv;
        cyc();
        cyc();
        chk("beq_exec_aluop", 64'(alu_op), 1);
        chk("beq_exec_retired", 64'(retired), 0);
        cyc();
        chk("beq_pc", 64'(pc), 64'(exp_pc));
        chk("beq_retired", 64'(retired), 1);
        chk("beq_instret", 64'(instret), 64'(exp_ret));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_pc", 64'(pc), 0);
        chk("rst_instret", 64'(instret), 0);
        chk("rst_trap", 64'(trap), 0);
        chk("rst_req", 64'(mem_bus.mem_req), 1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        zero  = 1'b0;
        imm   = '0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("reset_pc", 64'(pc), 0);
        chk("reset_instr", 64'(instr), 0);
        chk("reset_instret", 64'(instret), 0);
        chk("reset_retired", 64'(retired), 0);
        chk("reset_trap", 64'(trap), 0);
        chk("reset_cause", 64'(trap_cause), 0);
        chk("reset_req", 64'(mem_bus.mem_req), 1);
        chk("reset_we", 64'(mem_bus.mem_we), 0);
        chk("reset_regwe", 64'(reg_we), 0);
        rst_n = 1'b1;

        // R-type, zero wait: cycle by cycle
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = InstrR;
        chk("t1_c0_req", 64'(mem_bus.mem_req), 1);
        chk("t1_c0_sel", 64'(mem_bus.mem_addr_sel), 0);
        chk("t1_c0_regwe", 64'(reg_we), 0);
        cyc();
        chk("t1_c1_instr", 64'(instr), 64'(InstrR));
        chk("t1_c1_req", 64'(mem_bus.mem_req), 0);
        chk("t1_c1_regwe", 64'(reg_we), 0);
        chk("t1_c1_aluop", 64'(alu_op), 0);
        cyc();
        chk("t1_c2_aluop", 64'(alu_op), 2);
        chk("t1_c2_alusrc", 64'(alu_src), 0);
        chk("t1_c2_regwe", 64'(reg_we), 0);
        cyc();
        chk("t1_c3_regwe", 64'(reg_we), 1);
        chk("t1_c3_memtoreg", 64'(mem_to_reg), 0);
        chk("t1_c3_pc", 64'(pc), 0);
        cyc();
        chk("t1_c4_pc", 64'(pc), 4);
        chk("t1_c4_retired", 64'(retired), 1);
        chk("t1_c4_instret", 64'(instret), 1);
        chk("t1_c4_regwe", 64'(reg_we), 0);

        // Walk PC to 0x10 then branch tests
        do_r(8'h04, 2);
        do_r(8'h08, 3);
        do_r(8'h0C, 4);
        do_beq(8'h10, 1'b1, ImmM8, 8'h08, 5);
        do_r(8'h08, 6);
        do_r(8'h0C, 7);
        do_beq(8'h10, 1'b0, ImmM8, 8'h14, 8);
        do_beq(8'h14, 1'b1, 64'd232, 8'hFC, 9);
        do_beq(8'hFC, 1'b0, ImmM8, 8'h00, 10);

        // ld with 3 MEM wait-states: 8 cycles total
        mem_bus.mem_rdata = InstrLd;
        mem_bus.mem_ready = 1'b1;
        cyc();
        cyc();
        chk("ld_exec_alusrc", 64'(alu_src), 1);
        chk("ld_exec_aluop", 64'(alu_op), 0);
        chk("ld_exec_req", 64'(mem_bus.mem_req), 0);
        mem_bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ld_mem_req", 64'(mem_bus.mem_req), 1);
            chk("ld_mem_sel", 64'(mem_bus.mem_addr_sel), 1);
            chk("ld_mem_we", 64'(mem_bus.mem_we), 0);
            chk("ld_mem_alusrc", 64'(alu_src), 1);
            if (i == 3) mem_bus.mem_ready = 1'b1;
        end
        cyc();
        chk("ld_wb_regwe", 64'(reg_we), 1);
        chk("ld_wb_memtoreg", 64'(mem_to_reg), 1);
        chk("ld_wb_req", 64'(mem_bus.mem_req), 0);
        chk("ld_wb_retired", 64'(retired), 0);
        cyc();
        chk("ld_done_pc", 64'(pc), 4);
        chk("ld_done_retired", 64'(retired), 1);
        chk("ld_done_instret", 64'(instret), 11);

        // Ready arriving on the 15th fetch cycle is accepted
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = InstrR;
        for (int i = 0; i < 14; i++) cyc();
        chk("late_req", 64'(mem_bus.mem_req), 1);
        chk("late_trap", 64'(trap), 0);
        mem_bus.mem_ready = 1'b1;
        cyc();
        chk("late_dec_trap", 64'(trap), 0);
        chk("late_dec_instr", 64'(instr), 64'(InstrR));
        chk("late_dec_req", 64'(mem_bus.mem_req), 0);
        cyc();
        cyc();
        cyc();
        chk("late_done_pc", 64'(pc), 8);
        chk("late_done_instret", 64'(instret), 12);

        // Fetch timeout after 15 not-ready cycles
        mem_bus.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_wait_req", 64'(mem_bus.mem_req), 1);
            chk("to_wait_trap", 64'(trap), 0);
            cyc();
        end
        chk("to_trap", 64'(trap), 1);
        chk("to_cause", 64'(trap_cause), 2);
        chk("to_req", 64'(mem_bus.mem_req), 0);
        chk("to_pc", 64'(pc), 8);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = InstrLd;
        repeat (3) cyc();
        chk("to_sticky_trap", 64'(trap), 1);
        chk("to_sticky_pc", 64'(pc), 8);
        chk("to_sticky_instr", 64'(instr), 64'(InstrR));
        chk("to_sticky_instret", 64'(instret), 12);
        chk("to_sticky_req", 64'(mem_bus.mem_req), 0);

        // Illegal opcode
        do_reset();
        do_r(8'h00, 1);
        mem_bus.mem_rdata = InstrIll;
        mem_bus.mem_ready = 1'b1;
        cyc();
        chk("ill_dec_trap", 64'(trap), 0);
        cyc();
        chk("ill_trap", 64'(trap), 1);
        chk("ill_cause", 64'(trap_cause), 1);
        chk("ill_instret", 64'(instret), 1);
        chk("ill_instr", 64'(instr), 64'(InstrIll));
        chk("ill_pc", 64'(pc), 4);
        chk("ill_aluop", 64'(alu_op), 0);

        // Reset during sd MEM wait
        do_reset();
        do_r(8'h00, 1);
        mem_bus.mem_rdata = InstrSd;
        mem_bus.mem_ready = 1'b1;
        cyc();
        cyc();
        chk("sd_exec_we", 64'(mem_bus.mem_we), 0);
        chk("sd_exec_alusrc", 64'(alu_src), 1);
        mem_bus.mem_ready = 1'b0;
        cyc();
        chk("sd_mem_we", 64'(mem_bus.mem_we), 1);
        chk("sd_mem_sel", 64'(mem_bus.mem_addr_sel), 1);
        cyc();
        chk("sd_mem_we_hold", 64'(mem_bus.mem_we), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("sdrst_we", 64'(mem_bus.mem_we), 0);
        chk("sdrst_sel", 64'(mem_bus.mem_addr_sel), 0);
        chk("sdrst_req", 64'(mem_bus.mem_req), 1);
        chk("sdrst_pc", 64'(pc), 0);
        chk("sdrst_instret", 64'(instret), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("sdrst_restart_pc", 64'(pc), 0);
        chk("sdrst_restart_sel", 64'(mem_bus.mem_addr_sel), 0);

        // sd with zero wait-states: 4 cycles
        mem_bus.mem_rdata = InstrSd;
        mem_bus.mem_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("sd0_mem_we", 64'(mem_bus.mem_we), 1);
        chk("sd0_mem_retired", 64'(retired), 0);
        cyc();
        chk("sd0_pc", 64'(pc), 4);
        chk("sd0_retired", 64'(retired), 1);
        chk("sd0_instret", 64'(instret), 1);
        chk("sd0_we", 64'(mem_bus.mem_we), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
